// File: rtl/lif_pkg.sv
// lif_pkg
// Shared definitions for the leaky integrate-and-fire neuron core:
//   - lif_state_e   : sequencing states of the core (IDLE, ACCUM, UPDATE, DONE)
//   - LIF_RST_ZERO  : reset_mode value that clears the membrane on a fire
//   - LIF_RST_SUB   : reset_mode value that subtracts the threshold on a fire
//   - sat_signed    : clamps a 64-bit signed value into a signed range whose
//                     width is chosen by the caller; the caller truncates the
//                     result to that width
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } lif_state_e;

  localparam logic LIF_RST_ZERO = 1'b0;
  localparam logic LIF_RST_SUB  = 1'b1;

  // Bounds are derived from the requested width, so one helper serves every
  // datapath width as long as it is below 64 bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// lif_update_unit
// Purely combinational membrane update for one timestep:
//   leak toward zero, saturation, threshold compare and fire reset.
// Ports:
//   v           : signed membrane potential before the update
//   acc         : signed synaptic sum of this timestep
//   leak_value  : unsigned leak magnitude
//   threshold   : signed firing threshold
//   reset_mode  : LIF_RST_ZERO clears on fire, LIF_RST_SUB subtracts threshold
//   next_v      : signed membrane potential after the update
//   fire        : saturated potential reached the threshold
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int V_W   = 16,
  parameter int ACC_W = 20
) (
  input  logic signed [V_W-1:0]   v,
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [V_W-2:0]   leak_value,
  input  logic signed [V_W-1:0]   threshold,
  input  logic                    reset_mode,
  output logic signed [V_W-1:0]   next_v,
  output logic                    fire
);

  // One bit wider than the accumulator so V + acc can never wrap.
  localparam int SUM_W = ACC_W + 1;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] leak_ext;
  logic signed [SUM_W-1:0] leaked;
  logic signed [V_W-1:0]   sat_val;
  logic signed [V_W:0]     diff;

  // Leak pulls the potential toward zero but never across it; only the
  // leaked result is saturated so large sums still leak correctly.
  always_comb begin
    sum      = SUM_W'(v) + SUM_W'(acc);
    leak_ext = SUM_W'({1'b0, leak_value});
    leaked   = sum;
    if (sum > 0) begin
      leaked = (sum > leak_ext) ? sum - leak_ext : '0;
    end else if (sum < 0) begin
      leaked = (-sum > leak_ext) ? sum + leak_ext : '0;
    end
    sat_val = V_W'(sat_signed(64'(leaked), V_W));
    fire    = (sat_val >= threshold);
    diff    = (V_W+1)'(sat_val) - (V_W+1)'(threshold);
    if (!fire) begin
      next_v = sat_val;
    end else if (reset_mode == LIF_RST_SUB) begin
      next_v = V_W'(sat_signed(64'(diff), V_W));
    end else begin
      next_v = '0;
    end
  end

endmodule

// File: rtl/lif_neuron_core.sv
// lif_neuron_core
// Leaky integrate-and-fire neuron: one accepted input transaction is one
// timestep. Synapses are summed serially (one per cycle), then a single
// UPDATE cycle applies leak, saturation, threshold and refractory logic.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   in_valid / in_ready         : timestep handshake (ready only in IDLE)
//   spike_in, weight            : presynaptic spikes and packed signed weights
//   threshold, leak_value       : signed threshold, unsigned leak magnitude
//   reset_mode, tref            : fire reset style, refractory length
//   out_valid / out_ready       : result handshake (valid only in DONE)
//   spike_out                   : fired this timestep
//   memb_potential_out          : membrane potential after the update
//   refractory_out              : refractory counter nonzero after the update
// Build option: define LIF_REFRACTORY_EN to build the refractory counter;
// without it tref is ignored and refractory_out is tied low.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int WEIGHT_W   = 8,
  parameter int V_W        = 16,
  parameter int REF_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_INPUTS-1:0]          spike_in,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weight,
  input  logic [V_W-1:0]                 threshold,
  input  logic [V_W-2:0]                 leak_value,
  input  logic                           reset_mode,
  input  logic [REF_W-1:0]               tref,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           spike_out,
  output logic [V_W-1:0]                 memb_potential_out,
  output logic                           refractory_out
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int ACC_W = V_W + $clog2(NUM_INPUTS) + 1;

  lif_state_e state;
  lif_state_e next_state;

  logic [NUM_INPUTS-1:0]          spike_q;
  logic [NUM_INPUTS*WEIGHT_W-1:0] weight_q;
  logic signed [V_W-1:0]          thr_q;
  logic [V_W-2:0]                 leak_q;
  logic                           mode_q;
  logic signed [ACC_W-1:0]        acc;
  logic [IDX_W-1:0]               idx;
  logic signed [V_W-1:0]          v;
  logic signed [V_W-1:0]          next_v;
  logic                           fire;
  logic signed [WEIGHT_W-1:0]     w_sel;

`ifdef LIF_REFRACTORY_EN
  logic [REF_W-1:0] tref_q;
  logic [REF_W-1:0] ref_cnt;
`else
  logic unused_tref;
  assign unused_tref    = ^tref;
  assign refractory_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: the ACCUM stay lasts exactly NUM_INPUTS cycles, so the
  // latency is the same whether or not the timestep is refractory.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = ACCUM;
      ACCUM:   if (idx == IDX_W'(NUM_INPUTS - 1)) next_state = UPDATE;
      UPDATE:  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign w_sel              = weight_q[int'(idx)*WEIGHT_W +: WEIGHT_W];
  assign memb_potential_out = v;

  lif_update_unit #(
    .V_W   (V_W),
    .ACC_W (ACC_W)
  ) u_update (
    .v          (v),
    .acc        (acc),
    .leak_value (leak_q),
    .threshold  (thr_q),
    .reset_mode (mode_q),
    .next_v     (next_v),
    .fire       (fire)
  );

  // Datapath: inputs are captured at acceptance so the producer may change
  // them freely; V and the result outputs move only on the UPDATE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_q   <= '0;
      weight_q  <= '0;
      thr_q     <= '0;
      leak_q    <= '0;
      mode_q    <= LIF_RST_ZERO;
      acc       <= '0;
      idx       <= '0;
      v         <= '0;
      spike_out <= 1'b0;
`ifdef LIF_REFRACTORY_EN
      tref_q         <= '0;
      ref_cnt        <= '0;
      refractory_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            spike_q  <= spike_in;
            weight_q <= weight;
            thr_q    <= threshold;
            leak_q   <= leak_value;
            mode_q   <= reset_mode;
            acc      <= '0;
            idx      <= '0;
`ifdef LIF_REFRACTORY_EN
            tref_q   <= tref;
`endif
          end
        end
        ACCUM: begin
          if (spike_q[idx]) begin
            acc <= acc + ACC_W'(w_sel);
          end
          idx <= idx + IDX_W'(1);
        end
        UPDATE: begin
`ifdef LIF_REFRACTORY_EN
          // A refractory timestep throws away its synaptic sum entirely.
          if (ref_cnt != '0) begin
            v              <= '0;
            spike_out      <= 1'b0;
            ref_cnt        <= ref_cnt - REF_W'(1);
            refractory_out <= (ref_cnt != REF_W'(1));
          end else begin
            v         <= next_v;
            spike_out <= fire;
            if (fire) begin
              ref_cnt        <= tref_q;
              refractory_out <= (tref_q != '0);
            end else begin
              refractory_out <= 1'b0;
            end
          end
`else
          v         <= next_v;
          spike_out <= fire;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb_lif_neuron_core
// Self-checking bench for lif_neuron_core. Two instances share stimulus
// buses: a default V_W=16 core and a V_W=8 core for saturation cases.
// A timestep-level model predicts each result; a compare process checks the
// outputs of either core on every cycle its result is valid.
// Honours LIF_REFRACTORY_EN in the model when the build defines it.
module tb_lif_neuron_core;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             out_ready;
  logic [N-1:0]     spike_in;
  logic [N*8-1:0]   weight;
  logic             mode;
  logic [3:0]       tref;

  logic             in_valid_a, in_ready_a, out_valid_a, spike_a, refr_a;
  logic [15:0]      thr_a;
  logic [14:0]      leak_a;
  logic signed [15:0] memb_a;

  logic             in_valid_b, in_ready_b, out_valid_b, spike_b, refr_b;
  logic [7:0]       thr_b;
  logic [6:0]       leak_b;
  logic signed [7:0] memb_b;

  lif_neuron_core #(.NUM_INPUTS(N), .WEIGHT_W(8), .V_W(16), .REF_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .spike_in(spike_in), .weight(weight), .threshold(thr_a), .leak_value(leak_a),
    .reset_mode(mode), .tref(tref), .out_valid(out_valid_a), .out_ready(out_ready),
    .spike_out(spike_a), .memb_potential_out(memb_a), .refractory_out(refr_a)
  );

  lif_neuron_core #(.NUM_INPUTS(N), .WEIGHT_W(8), .V_W(8), .REF_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .spike_in(spike_in), .weight(weight), .threshold(thr_b), .leak_value(leak_b),
    .reset_mode(mode), .tref(tref), .out_valid(out_valid_b), .out_ready(out_ready),
    .spike_out(spike_b), .memb_potential_out(memb_b), .refractory_out(refr_b)
  );

  int checks = 0;
  int errors = 0;

  longint m_v[2]       = '{0, 0};
  int     m_ref[2]     = '{0, 0};
  bit     exp_spike[2] = '{0, 0};
  longint exp_v[2]     = '{0, 0};
  bit     exp_ref[2]   = '{0, 0};

  logic [N*8-1:0] wv;
  logic [N-1:0]   sp;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic longint clampTo(input longint x, input int vw);
    longint hi;
    hi = (longint'(1) <<< (vw - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi - 1;
    return x;
  endfunction

  function automatic logic [N*8-1:0] wAll(input int w);
    logic [N*8-1:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = w[7:0];
    return r;
  endfunction

  // Timestep model: integer arithmetic straight from the neuron's rules.
  task automatic modelStep(input int s, input logic [N-1:0] spk, input logic [N*8-1:0] wvec,
                           input longint thr, input longint leak, input bit md, input int tr);
    int     vw;
    longint acc;
    longint x;
    vw  = (s == 0) ? 16 : 8;
    acc = 0;
    for (int i = 0; i < N; i++)
      if (spk[i]) acc += longint'($signed(wvec[i*8 +: 8]));
`ifdef LIF_REFRACTORY_EN
    if (m_ref[s] > 0) begin
      m_ref[s]--;
      m_v[s]       = 0;
      exp_spike[s] = 1'b0;
      exp_v[s]     = 0;
      exp_ref[s]   = (m_ref[s] > 0);
      return;
    end
`endif
    x = m_v[s] + acc;
    if (x > 0) x = (x > leak) ? x - leak : 0;
    else if (x < 0) x = (-x > leak) ? x + leak : 0;
    x = clampTo(x, vw);
    if (x >= thr) begin
      exp_spike[s] = 1'b1;
      m_v[s]       = md ? clampTo(x - thr, vw) : 0;
`ifdef LIF_REFRACTORY_EN
      m_ref[s]     = tr;
`endif
    end else begin
      exp_spike[s] = 1'b0;
      m_v[s]       = x;
    end
    exp_v[s] = m_v[s];
`ifdef LIF_REFRACTORY_EN
    exp_ref[s] = (m_ref[s] > 0);
`else
    exp_ref[s] = (tr < 0);
`endif
  endtask

  task automatic setValid(input int s, input logic val);
    if (s == 0) in_valid_a = val;
    else        in_valid_b = val;
  endtask

  // One full timestep: offer, accept, measure latency, optional backpressure,
  // result handshake and the return of in_ready.
  task automatic applyStimulus(input int s, input logic [N-1:0] spk, input logic [N*8-1:0] wvec,
                               input longint thr, input longint leak, input bit md,
                               input int tr, input int hold);
    int lat;
    bit seen;
    modelStep(s, spk, wvec, thr, leak, md, tr);
    @(negedge clk);
    spike_in = spk;
    weight   = wvec;
    mode     = md;
    tref     = tr[3:0];
    if (s == 0) begin
      thr_a = thr[15:0];
      leak_a = leak[14:0];
    end else begin
      thr_b = thr[7:0];
      leak_b = leak[6:0];
    end
    setValid(s, 1'b1);
    checkOutput("accept_ready", (s == 0) ? in_ready_a : in_ready_b, 1);
    @(posedge clk);
    #1;
    setValid(s, 1'b0);
    spike_in = ~spk;
    weight   = ~wvec;
    thr_a    = ~thr_a;
    thr_b    = ~thr_b;
    mode     = ~md;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = (s == 0) ? out_valid_a : out_valid_b;
    end
    // out_valid appears on the tenth rising edge counting the accepting one.
    checkOutput("latency", lat, N + 2);
    if (!seen) return;
    for (int h = 0; h < hold; h++) begin
      checkOutput("bp_in_ready", (s == 0) ? in_ready_a : in_ready_b, 0);
      checkOutput("bp_out_valid", (s == 0) ? out_valid_a : out_valid_b, 1);
      setValid(s, h[0] ? 1'b0 : 1'b1);
      weight = {$urandom(), $urandom()};
      @(negedge clk);
    end
    setValid(s, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("post_in_ready", (s == 0) ? in_ready_a : in_ready_b, 1);
    checkOutput("post_out_valid", (s == 0) ? out_valid_a : out_valid_b, 0);
  endtask

  // Compare process: every cycle a result is valid it must match the model.
  always @(negedge clk) begin
    if (!reset && out_valid_a) begin
      checkOutput("cmp_a_spike", spike_a, exp_spike[0]);
      checkOutput("cmp_a_v", memb_a, exp_v[0]);
      checkOutput("cmp_a_refr", refr_a, exp_ref[0]);
    end
    if (!reset && out_valid_b) begin
      checkOutput("cmp_b_spike", spike_b, exp_spike[1]);
      checkOutput("cmp_b_v", memb_b, exp_v[1]);
      checkOutput("cmp_b_refr", refr_b, exp_ref[1]);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    spike_in = '0; weight = '0; mode = 1'b0; tref = '0;
    thr_a = '0; leak_a = '0; thr_b = '0; leak_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready_a, 1);
    checkOutput("rst_out_valid", out_valid_a, 0);
    checkOutput("rst_spike", spike_a, 0);
    checkOutput("rst_v", memb_a, 0);
    checkOutput("rst_refr", refr_a, 0);
    checkOutput("rst_b_in_ready", in_ready_b, 1);

    // Asynchronous reset in the middle of ACCUM discards the timestep.
    spike_in = '1; weight = wAll(50); thr_a = 16'd100; leak_a = '0; in_valid_a = 1'b1;
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", in_ready_a, 1);
    checkOutput("midrst_out_valid", out_valid_a, 0);
    checkOutput("midrst_v", memb_a, 0);
    @(negedge clk);
    reset = 1'b0;

    // Integrate from V=0: 10 + 20 - leak 5 = 25, w1 masked.
    wv = wAll(7); wv[7:0] = 8'd10; wv[15:8] = 8'd99; wv[23:16] = 8'd20;
    applyStimulus(0, 8'b0000_0101, wv, 100, 5, 1'b0, 0, 0);
    checkOutput("integ_v", memb_a, 25);
    checkOutput("integ_spike", spike_a, 0);
    checkOutput("integ_model_v", exp_v[0], 25);

    // Climb to 90 with out_ready held low for 5 cycles.
    wv = wAll(0); wv[7:0] = 8'd65;
    applyStimulus(0, 8'b0000_0001, wv, 100, 0, 1'b0, 0, 5);
    checkOutput("bp_v", memb_a, 90);

    // Fire with reset-to-zero and a 2-step refractory period.
    wv[7:0] = 8'd20;
    applyStimulus(0, 8'b0000_0001, wv, 100, 0, 1'b0, 2, 0);
    checkOutput("fire_spike", spike_a, 1);
    checkOutput("fire_v", memb_a, 0);
`ifdef LIF_REFRACTORY_EN
    checkOutput("fire_refr", refr_a, 1);
`endif
    applyStimulus(0, 8'hFF, wAll(50), 100, 0, 1'b0, 2, 0);
`ifdef LIF_REFRACTORY_EN
    checkOutput("refr1_spike", spike_a, 0);
    checkOutput("refr1_v", memb_a, 0);
`endif
    applyStimulus(0, 8'hFF, wAll(50), 100, 0, 1'b0, 2, 0);
`ifdef LIF_REFRACTORY_EN
    checkOutput("refr2_refr", refr_a, 0);
`endif
    // 400 fires; subtract mode leaves 300.
    applyStimulus(0, 8'hFF, wAll(50), 100, 0, 1'b1, 0, 0);
    checkOutput("after_refr_spike", spike_a, 1);
    checkOutput("after_refr_v", memb_a, 300);

    // Leak 300 down to 90, then 90 + 30 fires by subtraction to 20.
    applyStimulus(0, 8'h00, wAll(0), 1000, 210, 1'b0, 0, 0);
    checkOutput("leak_v", memb_a, 90);
    wv = wAll(0); wv[7:0] = 8'd30;
    applyStimulus(0, 8'b0000_0001, wv, 100, 0, 1'b1, 0, 0);
    checkOutput("sub_v", memb_a, 20);
    checkOutput("sub_spike", spike_a, 1);

    // Go negative, then a leak larger than |V| stops at zero.
    wv[7:0] = 8'hE2;
    applyStimulus(0, 8'b0000_0001, wv, 100, 0, 1'b0, 0, 0);
    checkOutput("neg_v", memb_a, -10);
    applyStimulus(0, 8'h00, wAll(0), 100, 15, 1'b0, 0, 0);
    checkOutput("negleak_v", memb_a, 0);

    // Mixed patterns checked against the model only.
    for (int k = 0; k < 4; k++) begin
      wv = {$urandom(), $urandom()};
      sp = 8'($urandom());
      applyStimulus(0, sp, wv, longint'($urandom_range(0, 400)) - 200,
                    longint'($urandom_range(0, 40)), 1'($urandom()),
                    int'($urandom_range(0, 3)), k);
    end

    // V_W=8 core: saturation at both rails and on threshold subtraction.
    applyStimulus(1, 8'hFF, wAll(-128), 127, 0, 1'b0, 0, 0);
    checkOutput("sat_neg_v", memb_b, -128);
    checkOutput("sat_neg_spike", spike_b, 0);
    applyStimulus(1, 8'hFF, wAll(127), 127, 0, 1'b1, 0, 0);
    checkOutput("sat_pos_spike", spike_b, 1);
    checkOutput("sat_pos_v", memb_b, 0);
    applyStimulus(1, 8'hFF, wAll(127), -128, 0, 1'b1, 0, 2);
    checkOutput("sat_sub_v", memb_b, 127);
    checkOutput("sat_sub_spike", spike_b, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
